// File: rtl/bsg_zynq_uart_axil_arbiter_if.sv
// Bundles the requester-side and downstream-side handshake signals of the arbiter.
// The arbiter uses "master"; the requesters and downstream port together use "slave".
interface bsg_zynq_uart_axil_arbiter_if #(
  parameter int num_req_p     = 2,
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 32,
  parameter int outstanding_p = 4
);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int cnt_width_lp  = (outstanding_p + 1 > 1) ? $clog2(outstanding_p + 1) : 1;

  logic [num_req_p*data_width_p-1:0]  req_data_i;
  logic [num_req_p*addr_width_p-1:0]  req_addr_i;
  logic [num_req_p-1:0]               req_w_i;
  logic [num_req_p*mask_width_lp-1:0] req_wmask_i;
  logic [num_req_p-1:0]               req_v_i;
  logic [num_req_p-1:0]               req_ready_and_o;
  logic [data_width_p-1:0]            rsp_data_o;
  logic [num_req_p-1:0]               rsp_v_o;
  logic [num_req_p-1:0]               rsp_ready_and_i;
  logic [data_width_p-1:0]            data_o;
  logic [addr_width_p-1:0]            addr_o;
  logic                               w_o;
  logic [mask_width_lp-1:0]           wmask_o;
  logic                               v_o;
  logic                               ready_and_i;
  logic [data_width_p-1:0]            data_i;
  logic                               v_i;
  logic                               ready_and_o;
  logic [cnt_width_lp-1:0]            outstanding_o;
  logic                               err_o;

  modport master (
    input  req_data_i, req_addr_i, req_w_i, req_wmask_i, req_v_i, rsp_ready_and_i,
           ready_and_i, data_i, v_i,
    output req_ready_and_o, rsp_data_o, rsp_v_o, data_o, addr_o, w_o, wmask_o, v_o,
           ready_and_o, outstanding_o, err_o
  );

  modport slave (
    output req_data_i, req_addr_i, req_w_i, req_wmask_i, req_v_i, rsp_ready_and_i,
           ready_and_i, data_i, v_i,
    input  req_ready_and_o, rsp_data_o, rsp_v_o, data_o, addr_o, w_o, wmask_o, v_o,
           ready_and_o, outstanding_o, err_o
  );
endinterface

// File: rtl/bsg_zynq_uart_axil_arbiter.sv
// Round-robin command arbiter in front of one AXI-lite FIFO master, with an
// in-order tag FIFO that steers each response back to its issuing requester.
module bsg_zynq_uart_axil_arbiter #(
  parameter int num_req_p     = 2,
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 32,
  parameter int outstanding_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_zynq_uart_axil_arbiter_if.master bus
);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int tag_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp  = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_width_lp  = (outstanding_p + 1 > 1) ? $clog2(outstanding_p + 1) : 1;

  logic [tag_width_lp-1:0] prio_r;
  logic [tag_width_lp-1:0] tags_r [outstanding_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    err_r;

  logic                    found, full, empty, push, pop, head_ready;
  logic [tag_width_lp-1:0] grant, head;

  assign full  = (count_r == cnt_width_lp'(outstanding_p));
  assign empty = (count_r == '0);
  assign head  = tags_r[rd_ptr_r];

  // Scan requesters starting at the priority pointer, wrapping modulo num_req_p.
  always_comb begin : arb
    logic [tag_width_lp:0] sum;
    found = 1'b0;
    grant = '0;
    sum   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      sum = {1'b0, prio_r} + (tag_width_lp + 1)'(i);
      if (sum >= (tag_width_lp + 1)'(num_req_p)) sum = sum - (tag_width_lp + 1)'(num_req_p);
      if (!found && bus.req_v_i[sum[tag_width_lp-1:0]]) begin
        found = 1'b1;
        grant = sum[tag_width_lp-1:0];
      end
    end
  end

  always_comb begin
    bus.v_o             = found & ~full;
    bus.data_o          = '0;
    bus.addr_o          = '0;
    bus.w_o             = 1'b0;
    bus.wmask_o         = '0;
    bus.req_ready_and_o = '0;
    bus.rsp_v_o         = '0;
    head_ready          = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (bus.v_o && grant == tag_width_lp'(i)) begin
        bus.data_o             = bus.req_data_i[i*data_width_p +: data_width_p];
        bus.addr_o             = bus.req_addr_i[i*addr_width_p +: addr_width_p];
        bus.w_o                = bus.req_w_i[i];
        bus.wmask_o            = bus.req_wmask_i[i*mask_width_lp +: mask_width_lp];
        bus.req_ready_and_o[i] = bus.ready_and_i;
      end
      if (head == tag_width_lp'(i)) begin
        bus.rsp_v_o[i] = bus.v_i & ~empty;
        head_ready     = bus.rsp_ready_and_i[i];
      end
    end
  end

  assign bus.rsp_data_o    = bus.data_i;
  assign bus.ready_and_o   = ~empty & head_ready;
  assign bus.outstanding_o = count_r;
  assign bus.err_o         = err_r;
  assign push              = bus.v_o & bus.ready_and_i;
  assign pop               = bus.v_i & bus.ready_and_o;

  // Explicit wraps keep non-power-of-2 requester counts and FIFO depths correct.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_r   <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
      for (int i = 0; i < outstanding_p; i++) tags_r[i] <= '0;
    end else begin
      if (push) begin
        tags_r[wr_ptr_r] <= grant;
        prio_r   <= (grant == tag_width_lp'(num_req_p - 1)) ? '0 : grant + tag_width_lp'(1);
        wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(outstanding_p - 1)) ? '0 : wr_ptr_r + ptr_width_lp'(1);
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(outstanding_p - 1)) ? '0 : rd_ptr_r + ptr_width_lp'(1);
      end
      if (push && !pop) count_r <= count_r + cnt_width_lp'(1);
      else if (pop && !push) count_r <= count_r - cnt_width_lp'(1);
      if (bus.v_i && empty) err_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bsg_zynq_uart_axil_arbiter.sv
// Directed bench for the round-robin AXI-lite arbiter with hand-computed expectations.
module tb_bsg_zynq_uart_axil_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_zynq_uart_axil_arbiter_if #(.num_req_p(2), .addr_width_p(32), .data_width_p(32), .outstanding_p(4)) bus ();

  bsg_zynq_uart_axil_arbiter #(.num_req_p(2), .addr_width_p(32), .data_width_p(32), .outstanding_p(4)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then settle before checking.
  task automatic applyStimulus(input logic [1:0] v, input logic rdy, input logic vi,
                               input logic [31:0] di, input logic [1:0] rr);
    @(negedge clk);
    bus.req_v_i         = v;
    bus.ready_and_i     = rdy;
    bus.v_i             = vi;
    bus.data_i          = di;
    bus.rsp_ready_and_i = rr;
    #1;
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] m);
    bus.req_addr_i[i*32 +: 32] = a;
    bus.req_data_i[i*32 +: 32] = d;
    bus.req_w_i[i]             = w;
    bus.req_wmask_i[i*4 +: 4]  = m;
  endtask

  task automatic clearInputs();
    bus.req_v_i = '0; bus.ready_and_i = 1'b0; bus.v_i = 1'b0; bus.data_i = '0;
    bus.rsp_ready_and_i = '0; bus.req_addr_i = '0; bus.req_data_i = '0;
    bus.req_w_i = '0; bus.req_wmask_i = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    checkOutput("rst_err", 64'(bus.err_o), 64'd0);
    checkOutput("rst_v_o", 64'(bus.v_o), 64'd0);
    checkOutput("rst_ready_and_o", 64'(bus.ready_and_o), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready_and_o), 64'd0);
    checkOutput("rst_rsp_v", 64'(bus.rsp_v_o), 64'd0);
    rst = 1'b0;

    // Single requester read with a response three cycles later
    setReq(0, 32'h8, 32'h0, 1'b0, 4'h0);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("t1_req_ready", 64'(bus.req_ready_and_o), 64'h1);
    checkOutput("t1_v_o", 64'(bus.v_o), 64'h1);
    checkOutput("t1_addr", 64'(bus.addr_o), 64'h8);
    checkOutput("t1_w", 64'(bus.w_o), 64'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("t1_outstanding1", 64'(bus.outstanding_o), 64'd1);
    checkOutput("t1_addr_gated", 64'(bus.addr_o), 64'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hA5, 2'b11);
    checkOutput("t1_rsp_v", 64'(bus.rsp_v_o), 64'h1);
    checkOutput("t1_rsp_data", 64'(bus.rsp_data_o), 64'hA5);
    checkOutput("t1_ready_and_o", 64'(bus.ready_and_o), 64'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("t1_outstanding0", 64'(bus.outstanding_o), 64'd0);
    checkOutput("t1_rsp_v_idle", 64'(bus.rsp_v_o), 64'h0);

    // Round robin between two always-valid requesters, then fill-limit and routing
    doReset();
    setReq(0, 32'h100, 32'h1111, 1'b0, 4'hF);
    setReq(1, 32'h200, 32'h2222, 1'b1, 4'h3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
      checkOutput($sformatf("rr_grant%0d", k), 64'(bus.req_ready_and_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput($sformatf("rr_addr%0d", k), 64'(bus.addr_o), (k % 2 == 0) ? 64'h100 : 64'h200);
      checkOutput($sformatf("rr_data%0d", k), 64'(bus.data_o), (k % 2 == 0) ? 64'h1111 : 64'h2222);
      checkOutput($sformatf("rr_wmask%0d", k), 64'(bus.wmask_o), (k % 2 == 0) ? 64'hF : 64'h3);
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("rr_full_v_o", 64'(bus.v_o), 64'h0);
    checkOutput("rr_full_ready", 64'(bus.req_ready_and_o), 64'h0);
    checkOutput("rr_full_count", 64'(bus.outstanding_o), 64'd4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b1, 1'b1, 32'h50 + k, 2'b11);
      checkOutput($sformatf("rr_rsp_v%0d", k), 64'(bus.rsp_v_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput($sformatf("rr_rsp_data%0d", k), 64'(bus.rsp_data_o), 64'h50 + 64'(k));
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("rr_drained", 64'(bus.outstanding_o), 64'd0);
    checkOutput("rr_ptr_back_to_0", 64'(bus.req_ready_and_o), 64'h1);

    // Full: a pop frees a slot only for the following cycle
    doReset();
    setReq(1, 32'h300, 32'h33, 1'b1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
      checkOutput($sformatf("full_fire%0d", k), 64'(bus.req_ready_and_o), 64'h2);
    end
    applyStimulus(2'b10, 1'b1, 1'b1, 32'h77, 2'b11);
    checkOutput("full_blocked_v_o", 64'(bus.v_o), 64'h0);
    checkOutput("full_blocked_ready", 64'(bus.req_ready_and_o), 64'h0);
    checkOutput("full_count4", 64'(bus.outstanding_o), 64'd4);
    checkOutput("full_pop_ready", 64'(bus.ready_and_o), 64'h1);
    checkOutput("full_pop_rsp_v", 64'(bus.rsp_v_o), 64'h2);
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("full_count3", 64'(bus.outstanding_o), 64'd3);
    checkOutput("full_refire", 64'(bus.req_ready_and_o), 64'h2);
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("full_count4b", 64'(bus.outstanding_o), 64'd4);
    checkOutput("full_v_o_again0", 64'(bus.v_o), 64'h0);

    // In-order routing with head-of-line blocking
    doReset();
    setReq(0, 32'h10, 32'h0, 1'b0, 4'h0);
    setReq(1, 32'h20, 32'hBEEF, 1'b1, 4'hF);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("hol_issue0", 64'(bus.req_ready_and_o), 64'h1);
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("hol_issue1", 64'(bus.req_ready_and_o), 64'h2);
    checkOutput("hol_issue1_w", 64'(bus.w_o), 64'h1);
    checkOutput("hol_issue1_data", 64'(bus.data_o), 64'hBEEF);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 1'b1, 1'b1, 32'h11, 2'b10);
      checkOutput($sformatf("hol_stall_rsp_v%0d", k), 64'(bus.rsp_v_o), 64'h1);
      checkOutput($sformatf("hol_stall_ready%0d", k), 64'(bus.ready_and_o), 64'h0);
      checkOutput($sformatf("hol_stall_count%0d", k), 64'(bus.outstanding_o), 64'd2);
    end
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h11, 2'b11);
    checkOutput("hol_rsp0_v", 64'(bus.rsp_v_o), 64'h1);
    checkOutput("hol_rsp0_data", 64'(bus.rsp_data_o), 64'h11);
    checkOutput("hol_rsp0_ready", 64'(bus.ready_and_o), 64'h1);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h22, 2'b11);
    checkOutput("hol_rsp1_v", 64'(bus.rsp_v_o), 64'h2);
    checkOutput("hol_rsp1_data", 64'(bus.rsp_data_o), 64'h22);
    checkOutput("hol_rsp1_count", 64'(bus.outstanding_o), 64'd1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("hol_drained", 64'(bus.outstanding_o), 64'd0);

    // Response with nothing outstanding sets the sticky error
    doReset();
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h99, 2'b11);
    checkOutput("err_ready_and_o", 64'(bus.ready_and_o), 64'h0);
    checkOutput("err_rsp_v", 64'(bus.rsp_v_o), 64'h0);
    checkOutput("err_not_yet", 64'(bus.err_o), 64'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("err_set", 64'(bus.err_o), 64'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("err_sticky", 64'(bus.err_o), 64'h1);

    // Async reset mid-burst with two outstanding and the pointer at requester 1
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("ar_issue0", 64'(bus.req_ready_and_o), 64'h1);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("ar_issue1", 64'(bus.req_ready_and_o), 64'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("ar_count2", 64'(bus.outstanding_o), 64'd2);
    checkOutput("ar_err_before", 64'(bus.err_o), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_async_count", 64'(bus.outstanding_o), 64'd0);
    checkOutput("ar_async_err", 64'(bus.err_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("ar_grant_after", 64'(bus.req_ready_and_o), 64'h1);
    checkOutput("ar_err_after", 64'(bus.err_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_zynq_uart_axil_arbiter.md
Name: bsg_zynq_uart_axil_arbiter

Overview:
Round-robin arbiter that shares one AXI-lite FIFO-style command/response port between num_req_p requesters. Example requesters are the UART bridge RX poller, the TX response path and a debug/host agent. It sits between the requesters and a single bsg_axil_fifo_master instance. An in-order tag FIFO routes each response back to the requester that issued the matching command.

Parameters:
num_req_p, 2, number of requesters (>=2)
addr_width_p, 32, command address width
data_width_p, 32, command/response data width
outstanding_p, 4, max in-flight commands (tag FIFO depth, >=1)
Derived: mask_width_lp = data_width_p/8; tag_width_lp = `BSG_SAFE_CLOG2(num_req_p); cnt_width_lp = `BSG_SAFE_CLOG2(outstanding_p+1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
req_data_i  in  num_req_p*data_width_p  per-requester write data, requester i at slice i
req_addr_i  in  num_req_p*addr_width_p  per-requester address
req_w_i  in  num_req_p  1=write, 0=read
req_wmask_i  in  num_req_p*mask_width_lp  write byte mask
req_v_i  in  num_req_p  command valid
req_ready_and_o  out  num_req_p  command accepted (one-hot or zero)
rsp_data_o  out  data_width_p  response data, broadcast to all requesters
rsp_v_o  out  num_req_p  response valid, one-hot to the owner
rsp_ready_and_i  in  num_req_p  requester response ready
data_o  out  data_width_p  downstream write data
addr_o  out  addr_width_p  downstream address
w_o  out  1  downstream write
wmask_o  out  mask_width_lp  downstream byte mask
v_o  out  1  downstream command valid
ready_and_i  in  1  downstream command ready
data_i  in  data_width_p  downstream response data
v_i  in  1  downstream response valid
ready_and_o  out  1  downstream response ready
outstanding_o  out  cnt_width_lp  in-flight command count
err_o  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset (async, active-high): priority pointer=0; tag FIFO empty (rd/wr pointers=0, count=0); err_o=0. All handshake outputs evaluate to 0 while the FIFO is empty and no req_v_i is high.
- Arbitration is combinational each cycle:
  - Grant goes to the first i with req_v_i[i]=1, scanning from the pointer upward with wrap modulo num_req_p.
  - Issue is only allowed when count < outstanding_p.
  - When blocked, v_o=0 and all req_ready_and_o=0.
- v_o = any valid & not full. data_o/addr_o/w_o/wmask_o are muxed from the granted slice; they are 0 when v_o=0.
- req_ready_and_o[g] = ready_and_i & v_o. Zero-latency pass-through; no command register.
- On issue fire (v_o & ready_and_i):
  - Push g into the tag FIFO.
  - Pointer <= (g+1) mod num_req_p. With non-power-of-2 num_req_p, wrap explicitly from num_req_p-1 to 0.
  - If no fire, the pointer holds.
- Both reads and writes produce exactly one downstream response; every push expects one pop.
- Response path, with head = tag at the FIFO read pointer:
  - rsp_v_o[head] = v_i & ~empty; other bits are 0.
  - rsp_data_o = data_i.
  - ready_and_o = ~empty & rsp_ready_and_i[head].
  - Pop on v_i & ready_and_o.
- Responses return strictly in issue order. A requester whose response is at the head and which deasserts ready stalls all later responses. This head-of-line blocking is intended.
- Simultaneous push and pop: count unchanged, both pointers advance. Full status is evaluated from the registered count, so a same-cycle pop does NOT permit a push when full.
- Pointer wrap: FIFO pointers wrap at outstanding_p-1 -> 0, including for non-power-of-2 depths.
- Response with an empty FIFO (v_i=1, count=0): ready_and_o=0 (response not consumed), err_o<=1. err_o holds until reset.
- outstanding_o = count, registered.
- Reset mid-transaction clears all state; in-flight downstream responses are the system's responsibility.

Test Plan:
- Single requester: req 0 reads 0x8, downstream ready=1 with a 3-cycle response of 0xA5 -> req_ready_and_o=01 in cycle 0, outstanding_o=1, rsp_v_o=01 with rsp_data_o=0xA5, outstanding_o returns to 0.
- Round robin: both requesters hold valid for 4 issues, ready_and_i=1 -> grant sequence 0,1,0,1, pointer ends at 0.
- Full: outstanding_p=4, responses withheld, requester 1 issues continuously -> exactly 4 fires, then v_o=0. One response pop frees the slot for an issue on the next cycle, not the same cycle.
- In-order routing and head-of-line blocking:
  - Issue req0 read then req1 write. Responses 0x11 then 0x22 -> rsp_v_o=01 with 0x11, then rsp_v_o=10 with 0x22.
  - With rsp_ready_and_i[0]=0, ready_and_o stays 0 and the req1 response waits.
- Error: v_i=1 with nothing outstanding -> ready_and_o=0, err_o=1 next cycle, and err_o stays 1 until reset_i is pulsed.
- Async reset asserted mid-burst with 2 outstanding -> outstanding_o=0 and err_o=0 immediately (no clock edge needed); the pointer grants requester 0 first after release.
